// File: rtl/platform_position_if.sv
// Platform-descriptor handshake and platform-box outputs.
// master: the descriptor producer and the consumers of the box outputs.
// slave : platform_position_control.
interface platform_position_if;
  logic       sync_platform_position;
  logic [2:0] movement_direction;
  logic [4:0] speed;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [9:0] w;
  logic [9:0] h;
  logic [7:0] destroy_time;
  logic [1:0] destroy_trigger;
  logic       update_platform_position;
  logic [9:0] plat_x;
  logic [9:0] plat_y;
  logic [9:0] plat_w;
  logic [9:0] plat_h;
  logic       plat_active;

  modport master (
    output sync_platform_position, movement_direction, speed, pos_x, pos_y, w, h,
           destroy_time, destroy_trigger,
    input  update_platform_position, plat_x, plat_y, plat_w, plat_h, plat_active
  );

  modport slave (
    input  sync_platform_position, movement_direction, speed, pos_x, pos_y, w, h,
           destroy_time, destroy_trigger,
    output update_platform_position, plat_x, plat_y, plat_w, plat_h, plat_active
  );
endinterface

// File: rtl/platform_position_control.sv
// Platform position control: latches one platform descriptor per handshake,
// acknowledges it, then moves the box on every frame_tick until it is destroyed
// by its timer and/or screen-edge rule, or replaced by a newer descriptor.
// Build option: define PLATFORM_WRAP_EN to wrap x/y around the playfield instead
// of clamping; a wrap then counts as an edge hit.
module platform_position_control #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int DESTROY_SCALE = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                time_tick,
  platform_position_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACK    = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam logic signed [11:0] SCR_W = 12'(SCREEN_W);
  localparam logic signed [11:0] SCR_H = 12'(SCREEN_H);
  localparam logic [11:0]        SCALE = 12'(DESTROY_SCALE);

  logic [1:0]  state_r;
  logic [2:0]  dir_r;
  logic [4:0]  speed_r;
  logic [1:0]  trig_r;
  logic [11:0] count_r;
  logic        edge_hit_r;
  logic        ack_r;
  logic        active_r;
  logic [9:0]  plat_x_r;
  logic [9:0]  plat_y_r;
  logic [9:0]  plat_w_r;
  logic [9:0]  plat_h_r;

  logic        accept_s;
  logic        dec_x_s;
  logic        inc_x_s;
  logic        dec_y_s;
  logic        inc_y_s;
  logic [10:0] step_x_s;
  logic [10:0] step_y_s;
  logic        hit_now_s;
  logic        destroy_s;

  // One-axis move: returns {edge_hit, new_position}. The sum is carried in 12 bits
  // so a start corner anywhere in the 10-bit range cannot overflow the arithmetic.
  function automatic logic [10:0] axis_step(
    input logic [9:0]         cur,
    input logic [4:0]         spd,
    input logic               dec,
    input logic               inc,
    input logic [9:0]         size,
    input logic signed [11:0] screen
  );
    logic signed [11:0] nxt;
    logic signed [11:0] lim;
    logic               hit;
    nxt = signed'({2'b00, cur});
    hit = 1'b0;
    lim = 12'sd0;
    if (dec) begin
      nxt = nxt - signed'({7'b0000000, spd});
    end else if (inc) begin
      nxt = nxt + signed'({7'b0000000, spd});
    end else begin
      nxt = nxt;
    end
`ifdef PLATFORM_WRAP_EN
    lim = signed'({2'b00, size});
    lim = 12'sd0;
    if (!(dec || inc)) begin
      hit = 1'b0;
    end else if (nxt < 12'sd0) begin
      nxt = nxt + screen;
      hit = 1'b1;
    end else if (nxt >= screen) begin
      nxt = nxt - screen;
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
`else
    // A box at least as wide as the screen can only sit at 0.
    if (signed'({2'b00, size}) >= screen) begin
      lim = 12'sd0;
    end else begin
      lim = screen - signed'({2'b00, size});
    end
    if (!(dec || inc)) begin
      hit = 1'b0;
    end else if (nxt < 12'sd0) begin
      nxt = 12'sd0;
      hit = 1'b1;
    end else if (nxt > lim) begin
      nxt = lim;
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
`endif
    return {hit, nxt[9:0]};
  endfunction

  // Handshake trigger, per-direction axis decode, motion and destroy decisions.
  always_comb begin
    accept_s = !bus.sync_platform_position && !ack_r;
    dec_x_s  = 1'b0;
    inc_x_s  = 1'b0;
    dec_y_s  = 1'b0;
    inc_y_s  = 1'b0;
    case (dir_r)
      3'd1:    dec_y_s = 1'b1;
      3'd2:    inc_y_s = 1'b1;
      3'd3:    dec_x_s = 1'b1;
      3'd4:    inc_x_s = 1'b1;
      3'd5:    begin dec_x_s = 1'b1; dec_y_s = 1'b1; end
      3'd6:    begin inc_x_s = 1'b1; dec_y_s = 1'b1; end
      3'd7:    begin inc_x_s = 1'b1; inc_y_s = 1'b1; end
      default: begin dec_x_s = 1'b0; inc_x_s = 1'b0; end
    endcase
    step_x_s = axis_step(plat_x_r, speed_r, dec_x_s, inc_x_s, plat_w_r, SCR_W);
    step_y_s = axis_step(plat_y_r, speed_r, dec_y_s, inc_y_s, plat_h_r, SCR_H);
    // With both ticks in one cycle the destroy rule sees this tick's motion.
    if (frame_tick) begin
      hit_now_s = step_x_s[10] || step_y_s[10];
    end else begin
      hit_now_s = edge_hit_r;
    end
    destroy_s = (trig_r[0] && (count_r == 12'd0)) || (trig_r[1] && hit_now_s);
  end

  // Control FSM: descriptor latch, acknowledge, motion and lifetime.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      dir_r      <= 3'd0;
      speed_r    <= 5'd0;
      trig_r     <= 2'd0;
      count_r    <= 12'd0;
      edge_hit_r <= 1'b0;
      ack_r      <= 1'b0;
      active_r   <= 1'b0;
      plat_x_r   <= 10'd0;
      plat_y_r   <= 10'd0;
      plat_w_r   <= 10'd0;
      plat_h_r   <= 10'd0;
    end else if (accept_s && ((state_r == IDLE) || (state_r == ACTIVE))) begin
      // Accept wins over both ticks; the old box, if any, is replaced.
      state_r    <= ACK;
      dir_r      <= bus.movement_direction;
      speed_r    <= bus.speed;
      trig_r     <= bus.destroy_trigger;
      count_r    <= {4'b0000, bus.destroy_time} * SCALE;
      edge_hit_r <= 1'b0;
      ack_r      <= 1'b1;
      active_r   <= 1'b1;
      plat_x_r   <= bus.pos_x;
      plat_y_r   <= bus.pos_y;
      plat_w_r   <= bus.w;
      plat_h_r   <= bus.h;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        ACK: begin
          if (bus.sync_platform_position) begin
            ack_r   <= 1'b0;
            state_r <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (frame_tick) begin
            plat_x_r   <= step_x_s[9:0];
            plat_y_r   <= step_y_s[9:0];
            edge_hit_r <= step_x_s[10] || step_y_s[10];
          end
          if (time_tick) begin
            if (destroy_s) begin
              active_r <= 1'b0;
              state_r  <= IDLE;
            end else if (trig_r[0]) begin
              count_r <= count_r - 12'd1;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          ack_r    <= 1'b0;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.update_platform_position = ack_r;
  assign bus.plat_x                   = plat_x_r;
  assign bus.plat_y                   = plat_y_r;
  assign bus.plat_w                   = plat_w_r;
  assign bus.plat_h                   = plat_h_r;
  assign bus.plat_active              = active_r;

endmodule

// File: tb/tb_platform_position_control.sv
// Directed testbench for platform_position_control. Expected values are pushed
// onto a scoreboard queue as stimulus is driven and popped when outputs are sampled.
module tb_platform_position_control;
  logic clk;
  logic reset;
  logic frame_tick;
  logic time_tick;
  int   checks;
  int   failures;
  logic [31:0] exp_q[$];

  platform_position_if bus();

  platform_position_control dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .time_tick  (time_tick),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: observed=%0d, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
    end
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic time_pulse();
    time_tick = 1'b1;
    step();
    time_tick = 1'b0;
  endtask

  // Full handshake: sync low for one edge, then high; ack checked on both sides.
  task automatic handshake(input logic [2:0] dir, input logic [4:0] spd,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic [9:0] wd, input logic [9:0] ht,
                           input logic [7:0] dt, input logic [1:0] trig);
    bus.movement_direction     = dir;
    bus.speed                  = spd;
    bus.pos_x                  = x;
    bus.pos_y                  = y;
    bus.w                      = wd;
    bus.h                      = ht;
    bus.destroy_time           = dt;
    bus.destroy_trigger        = trig;
    bus.sync_platform_position = 1'b0;
    expect_val(32'd1);
    expect_val(32'(x));
    step();
    check("hs_ack_high", 32'(bus.update_platform_position));
    check("hs_x_loaded", 32'(bus.plat_x));
    bus.sync_platform_position = 1'b1;
    expect_val(32'd0);
    step();
    check("hs_ack_low", 32'(bus.update_platform_position));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    frame_tick = 1'b0;
    time_tick  = 1'b0;
    bus.sync_platform_position = 1'b1;
    bus.movement_direction = 3'd0;
    bus.speed = 5'd0;
    bus.pos_x = 10'd0;
    bus.pos_y = 10'd0;
    bus.w = 10'd0;
    bus.h = 10'd0;
    bus.destroy_time = 8'd0;
    bus.destroy_trigger = 2'd0;
    step();
    step();
    reset = 1'b0;
    step();
    expect_val(32'd0); check("rst_ack",    32'(bus.update_platform_position));
    expect_val(32'd0); check("rst_active", 32'(bus.plat_active));
    expect_val(32'd0); check("rst_x",      32'(bus.plat_x));
    expect_val(32'd0); check("rst_w",      32'(bus.plat_w));

    // 1: sync held low 5 cycles, one latch only
    bus.movement_direction = 3'd4;
    bus.speed = 5'd3;
    bus.pos_x = 10'd100;
    bus.pos_y = 10'd200;
    bus.w = 10'd40;
    bus.h = 10'd8;
    bus.destroy_time = 8'd0;
    bus.destroy_trigger = 2'b00;
    bus.sync_platform_position = 1'b0;
    step();
    expect_val(32'd1);   check("t1_ack",    32'(bus.update_platform_position));
    expect_val(32'd100); check("t1_x",      32'(bus.plat_x));
    expect_val(32'd1);   check("t1_active", 32'(bus.plat_active));
    bus.pos_x = 10'd500;
    for (int i = 0; i < 4; i++) step();
    expect_val(32'd100); check("t1_one_latch", 32'(bus.plat_x));
    expect_val(32'd1);   check("t1_ack_held",  32'(bus.update_platform_position));
    bus.sync_platform_position = 1'b1;
    step();
    expect_val(32'd0);   check("t1_ack_drop", 32'(bus.update_platform_position));

    // 2: ten frame ticks right at speed 3
    for (int i = 0; i < 10; i++) begin
      frame_pulse();
      step();
    end
    expect_val(32'd130); check("t2_x", 32'(bus.plat_x));
    expect_val(32'd200); check("t2_y", 32'(bus.plat_y));

    // 5: new descriptor coincides with frame_tick
    bus.movement_direction = 3'd1;
    bus.speed = 5'd5;
    bus.pos_x = 10'd50;
    bus.pos_y = 10'd60;
    bus.w = 10'd20;
    bus.h = 10'd10;
    bus.sync_platform_position = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    expect_val(32'd50); check("t5_x", 32'(bus.plat_x));
    expect_val(32'd60); check("t5_y", 32'(bus.plat_y));
    expect_val(32'd20); check("t5_w", 32'(bus.plat_w));
    bus.sync_platform_position = 1'b1;
    step();
    frame_pulse();
    expect_val(32'd55); check("t5_move_up", 32'(bus.plat_y));

`ifdef PLATFORM_WRAP_EN
    // 6: wrap on the right edge, then edge rule destroys
    handshake(3'd4, 5'd10, 10'd635, 10'd100, 10'd8, 10'd8, 8'd0, 2'b10);
    frame_pulse();
    expect_val(32'd5); check("t6_wrap_x",  32'(bus.plat_x));
    expect_val(32'd1); check("t6_active",  32'(bus.plat_active));
    time_pulse();
    expect_val(32'd0); check("t6_destroy", 32'(bus.plat_active));
`else
    // 3: left edge clamp, then edge rule destroys on the next time_tick
    handshake(3'd3, 5'd20, 10'd30, 10'd100, 10'd40, 10'd8, 8'd0, 2'b10);
    frame_pulse();
    expect_val(32'd10); check("t3_x1", 32'(bus.plat_x));
    frame_pulse();
    expect_val(32'd0);  check("t3_x_clamp", 32'(bus.plat_x));
    expect_val(32'd1);  check("t3_still_active", 32'(bus.plat_active));
    time_pulse();
    expect_val(32'd0);  check("t3_destroy", 32'(bus.plat_active));
    expect_val(32'd40); check("t3_w_kept",  32'(bus.plat_w));

    // right edge clamp at SCREEN_W-w, never-destroy rule keeps it alive
    handshake(3'd4, 5'd31, 10'd590, 10'd100, 10'd40, 10'd8, 8'd0, 2'b00);
    frame_pulse();
    expect_val(32'd600); check("clamp_right", 32'(bus.plat_x));
    time_pulse();
    expect_val(32'd1);   check("never_rule", 32'(bus.plat_active));

    // both ticks together: motion first, destroy on the fresh edge hit
    handshake(3'd4, 5'd10, 10'd595, 10'd100, 10'd40, 10'd8, 8'd0, 2'b10);
    time_pulse();
    expect_val(32'd1);   check("no_edge_yet", 32'(bus.plat_active));
    frame_tick = 1'b1;
    time_tick  = 1'b1;
    step();
    frame_tick = 1'b0;
    time_tick  = 1'b0;
    expect_val(32'd600); check("both_x",       32'(bus.plat_x));
    expect_val(32'd0);   check("both_destroy", 32'(bus.plat_active));
`endif

    // 4: timer rule, destroy_time=2 -> 20 decrements then destroy on tick 21
    handshake(3'd0, 5'd0, 10'd10, 10'd10, 10'd8, 10'd8, 8'd2, 2'b01);
    for (int i = 0; i < 19; i++) time_pulse();
    expect_val(32'd1); check("t4_after19", 32'(bus.plat_active));
    time_pulse();
    expect_val(32'd1); check("t4_after20", 32'(bus.plat_active));
    time_pulse();
    expect_val(32'd0); check("t4_after21", 32'(bus.plat_active));

    // destroy_time=0 with the timer rule dies on the first time_tick
    handshake(3'd0, 5'd0, 10'd20, 10'd20, 10'd8, 10'd8, 8'd0, 2'b01);
    time_pulse();
    expect_val(32'd0); check("dt0_destroy", 32'(bus.plat_active));

    // reset in the middle of motion
    handshake(3'd2, 5'd4, 10'd300, 10'd100, 10'd8, 10'd8, 8'd0, 2'b00);
    frame_pulse();
    expect_val(32'd104); check("pre_rst_y", 32'(bus.plat_y));
    reset = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    reset = 1'b0;
    expect_val(32'd0); check("mid_rst_active", 32'(bus.plat_active));
    expect_val(32'd0); check("mid_rst_x",      32'(bus.plat_x));
    expect_val(32'd0); check("mid_rst_y",      32'(bus.plat_y));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
